// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with input-side operand forwarding and bubble insertion.
// Optional bubble/flush statistics counters are enabled with `define BUBBLE_STAT_EN.
module id_ex_forward_reg #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Halt,
  input  logic          Flush,
  input  logic          Load_use,
  input  logic [1:0]    conflict_A,
  input  logic [1:0]    conflict_B,
  input  logic [DW-1:0] R1_data,
  input  logic [DW-1:0] R2_data,
  input  logic [DW-1:0] MEM_ALU_result,
  input  logic [DW-1:0] WB_Read_data,
  input  logic [DW-1:0] WB_ALU_result,
  input  logic          ID_valid,
  input  logic [DW-1:0] ID_PC,
  input  logic [DW-1:0] ID_imm,
  input  logic [AW-1:0] ID_Write_Reg,
  input  logic          ID_Reg_Write,
  input  logic          ID_Sel,
  input  logic          ID_Mem_Write,
  input  logic [3:0]    ID_ALU_op,
  output logic [DW-1:0] EX_A,
  output logic [DW-1:0] EX_B,
  output logic [DW-1:0] EX_PC,
  output logic [DW-1:0] EX_imm,
  output logic [AW-1:0] EX_Write_Reg,
  output logic          EX_Reg_Write,
  output logic          EX_Sel,
  output logic          EX_Mem_Write,
  output logic          EX_valid,
  output logic [3:0]    EX_ALU_op
`ifdef BUBBLE_STAT_EN
  ,
  output logic [31:0]   Bubble_count,
  output logic [31:0]   Flush_count
`endif
);

  logic [DW-1:0] fwd_a, fwd_b;
  logic [DW-1:0] a_d, a_q, b_d, b_q, pc_d, pc_q, imm_d, imm_q;
  logic [AW-1:0] write_reg_d, write_reg_q;
  logic          reg_write_d, reg_write_q, sel_d, sel_q, mem_write_d, mem_write_q;
  logic          valid_d, valid_q;
  logic [3:0]    alu_op_d, alu_op_q;
  logic          bubble;

  always_comb begin
    unique case (conflict_A)
      2'd1:    fwd_a = MEM_ALU_result;
      2'd2:    fwd_a = WB_Read_data;
      2'd3:    fwd_a = WB_ALU_result;
      default: fwd_a = R1_data;
    endcase
    unique case (conflict_B)
      2'd1:    fwd_b = MEM_ALU_result;
      2'd2:    fwd_b = WB_Read_data;
      2'd3:    fwd_b = WB_ALU_result;
      default: fwd_b = R2_data;
    endcase
  end

  // An invalid ID slot produces the same all-zero bubble as a hazard.
  assign bubble = Flush | Load_use | ~ID_valid;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    write_reg_d = write_reg_q;
    reg_write_d = reg_write_q;
    sel_d       = sel_q;
    mem_write_d = mem_write_q;
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    if (!Halt) begin
      if (bubble) begin
        a_d         = '0;
        b_d         = '0;
        pc_d        = '0;
        imm_d       = '0;
        write_reg_d = '0;
        reg_write_d = 1'b0;
        sel_d       = 1'b0;
        mem_write_d = 1'b0;
        valid_d     = 1'b0;
        alu_op_d    = '0;
      end else begin
        a_d         = fwd_a;
        b_d         = fwd_b;
        pc_d        = ID_PC;
        imm_d       = ID_imm;
        write_reg_d = ID_Write_Reg;
        reg_write_d = ID_Reg_Write;
        sel_d       = ID_Sel;
        mem_write_d = ID_Mem_Write;
        valid_d     = 1'b1;
        alu_op_d    = ID_ALU_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      sel_q       <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      sel_q       <= sel_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign EX_A         = a_q;
  assign EX_B         = b_q;
  assign EX_PC        = pc_q;
  assign EX_imm       = imm_q;
  assign EX_Write_Reg = write_reg_q;
  assign EX_Reg_Write = reg_write_q;
  assign EX_Sel       = sel_q;
  assign EX_Mem_Write = mem_write_q;
  assign EX_valid     = valid_q;
  assign EX_ALU_op    = alu_op_q;

`ifdef BUBBLE_STAT_EN
  logic [31:0] bubble_count_d, bubble_count_q, flush_count_d, flush_count_q;

  // Flush takes precedence: a simultaneous load-use is charged to Flush_count only.
  always_comb begin
    bubble_count_d = bubble_count_q;
    flush_count_d  = flush_count_q;
    if (!Halt) begin
      if (Flush && flush_count_q != '1)
        flush_count_d = flush_count_q + 32'd1;
      if (Load_use && !Flush && bubble_count_q != '1)
        bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign Bubble_count = bubble_count_q;
  assign Flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Directed self-checking bench for id_ex_forward_reg (counter checks when BUBBLE_STAT_EN is defined).
module tb_id_ex_forward_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Halt, Flush, Load_use;
  logic [1:0]  conflict_A, conflict_B;
  logic [31:0] R1_data, R2_data, MEM_ALU_result, WB_Read_data, WB_ALU_result;
  logic        ID_valid;
  logic [31:0] ID_PC, ID_imm;
  logic [4:0]  ID_Write_Reg;
  logic        ID_Reg_Write, ID_Sel, ID_Mem_Write;
  logic [3:0]  ID_ALU_op;
  logic [31:0] EX_A, EX_B, EX_PC, EX_imm;
  logic [4:0]  EX_Write_Reg;
  logic        EX_Reg_Write, EX_Sel, EX_Mem_Write, EX_valid;
  logic [3:0]  EX_ALU_op;
`ifdef BUBBLE_STAT_EN
  logic [31:0] Bubble_count, Flush_count;
  logic [31:0] exp_bub, exp_fl;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_forward_reg #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .Halt(Halt), .Flush(Flush), .Load_use(Load_use),
    .conflict_A(conflict_A), .conflict_B(conflict_B),
    .R1_data(R1_data), .R2_data(R2_data), .MEM_ALU_result(MEM_ALU_result),
    .WB_Read_data(WB_Read_data), .WB_ALU_result(WB_ALU_result),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_imm(ID_imm), .ID_Write_Reg(ID_Write_Reg),
    .ID_Reg_Write(ID_Reg_Write), .ID_Sel(ID_Sel), .ID_Mem_Write(ID_Mem_Write),
    .ID_ALU_op(ID_ALU_op),
    .EX_A(EX_A), .EX_B(EX_B), .EX_PC(EX_PC), .EX_imm(EX_imm),
    .EX_Write_Reg(EX_Write_Reg), .EX_Reg_Write(EX_Reg_Write), .EX_Sel(EX_Sel),
    .EX_Mem_Write(EX_Mem_Write), .EX_valid(EX_valid), .EX_ALU_op(EX_ALU_op)
`ifdef BUBBLE_STAT_EN
    , .Bubble_count(Bubble_count), .Flush_count(Flush_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    Halt = 0; Flush = 0; Load_use = 0;
    conflict_A = 0; conflict_B = 0;
    R1_data = 0; R2_data = 0; MEM_ALU_result = 0; WB_Read_data = 0; WB_ALU_result = 0;
    ID_valid = 1; ID_PC = 32'h40; ID_imm = 32'h8; ID_Write_Reg = 5'd3;
    ID_Reg_Write = 1; ID_Sel = 0; ID_Mem_Write = 0; ID_ALU_op = 4'h2;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    #12;
    n_cmp++;
    if ({EX_A, EX_B, EX_PC, EX_imm} !== 128'h0 ||
        {EX_Write_Reg, EX_Reg_Write, EX_Sel, EX_Mem_Write, EX_valid, EX_ALU_op} !== 13'h0) begin
      n_bad++; $display("FAIL reset_init: A=%h PC=%h valid=%b wr=%h", EX_A, EX_PC, EX_valid, EX_Write_Reg);
    end
    @(negedge clk); rst_n = 1;
    R1_data = 32'h1234;
    step();
    n_cmp++;
    if (EX_A !== 32'h1234 || EX_valid !== 1'b1) begin
      n_bad++; $display("FAIL reset_preload: A=%h valid=%b want 1234/1", EX_A, EX_valid);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (EX_A !== 32'h0 || EX_valid !== 1'b0 || EX_PC !== 32'h0 || EX_Reg_Write !== 1'b0 ||
        EX_Write_Reg !== 5'h0 || EX_ALU_op !== 4'h0 || EX_imm !== 32'h0) begin
      n_bad++; $display("FAIL reset_async: A=%h valid=%b PC=%h want all 0", EX_A, EX_valid, EX_PC);
    end
`ifdef BUBBLE_STAT_EN
    exp_bub = 0; exp_fl = 0;
    n_cmp++;
    if (Bubble_count !== 32'h0 || Flush_count !== 32'h0) begin
      n_bad++; $display("FAIL reset_counters: bub=%h fl=%h want 0/0", Bubble_count, Flush_count);
    end
`endif
    #2 rst_n = 1;
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'd1, 32'd2, 32'd3, 32'd4};
    exp_b = '{32'd4, 32'd3, 32'd2, 32'd1};
    set_idle();
    R1_data = 1; R2_data = 1; MEM_ALU_result = 2; WB_Read_data = 3; WB_ALU_result = 4;
    for (int i = 0; i < 4; i++) begin
      conflict_A = 2'(i);
      conflict_B = 2'(3 - i);
      ID_PC = 32'h100 + 32'(i); ID_ALU_op = 4'(i + 5);
      step();
      n_cmp++;
      if (EX_A !== exp_a[i] || EX_B !== exp_b[i]) begin
        n_bad++; $display("FAIL fwd_%0d: A=%h B=%h want %h %h", i, EX_A, EX_B, exp_a[i], exp_b[i]);
      end
      n_cmp++;
      if (EX_PC !== 32'h100 + 32'(i) || EX_ALU_op !== 4'(i + 5) || EX_valid !== 1'b1 ||
          EX_imm !== 32'h8 || EX_Write_Reg !== 5'd3) begin
        n_bad++; $display("FAIL fwd_ctrl_%0d: PC=%h op=%h valid=%b", i, EX_PC, EX_ALU_op, EX_valid);
      end
    end
  endtask

  task automatic test_load_use();
    set_idle();
    ID_Write_Reg = 5'd5; ID_Reg_Write = 1; ID_Sel = 1; ID_ALU_op = 4'h2;
    step();
    n_cmp++;
    if (EX_Sel !== 1'b1 || EX_Reg_Write !== 1'b1 || EX_Write_Reg !== 5'd5) begin
      n_bad++; $display("FAIL lw_in_ex: sel=%b rw=%b wr=%0d want 1 1 5", EX_Sel, EX_Reg_Write, EX_Write_Reg);
    end
    ID_Sel = 0; ID_Write_Reg = 5'd6; ID_Mem_Write = 1; Load_use = 1;
    step();
`ifdef BUBBLE_STAT_EN
    exp_bub++;
`endif
    n_cmp++;
    if (EX_valid !== 1'b0 || EX_Write_Reg !== 5'd0 || EX_Reg_Write !== 1'b0 || EX_Sel !== 1'b0 ||
        EX_Mem_Write !== 1'b0 || EX_ALU_op !== 4'h0 || EX_A !== 32'h0 || EX_PC !== 32'h0) begin
      n_bad++; $display("FAIL lu_bubble: valid=%b wr=%0d rw=%b mw=%b A=%h", EX_valid, EX_Write_Reg, EX_Reg_Write, EX_Mem_Write, EX_A);
    end
    Load_use = 0; conflict_A = 2; WB_Read_data = 32'hCAFE;
    step();
    n_cmp++;
    if (EX_A !== 32'hCAFE || EX_valid !== 1'b1 || EX_Write_Reg !== 5'd6 || EX_Mem_Write !== 1'b1) begin
      n_bad++; $display("FAIL lu_after: A=%h valid=%b wr=%0d want CAFE 1 6", EX_A, EX_valid, EX_Write_Reg);
    end
`ifdef BUBBLE_STAT_EN
    n_cmp++;
    if (Bubble_count !== exp_bub || Flush_count !== exp_fl) begin
      n_bad++; $display("FAIL lu_count: bub=%0d fl=%0d want %0d %0d", Bubble_count, Flush_count, exp_bub, exp_fl);
    end
`endif
  endtask

  task automatic test_flush_load_use();
    set_idle();
    R1_data = 32'h77;
    step();
    Flush = 1; Load_use = 1;
    step();
`ifdef BUBBLE_STAT_EN
    exp_fl++;
`endif
    n_cmp++;
    if (EX_valid !== 1'b0 || EX_A !== 32'h0 || EX_Reg_Write !== 1'b0 || EX_Write_Reg !== 5'd0) begin
      n_bad++; $display("FAIL fl_lu_bubble: valid=%b A=%h rw=%b", EX_valid, EX_A, EX_Reg_Write);
    end
    Flush = 0; Load_use = 0;
    step();
    n_cmp++;
    if (EX_valid !== 1'b1 || EX_A !== 32'h77) begin
      n_bad++; $display("FAIL fl_lu_single: valid=%b A=%h want 1 77", EX_valid, EX_A);
    end
`ifdef BUBBLE_STAT_EN
    n_cmp++;
    if (Bubble_count !== exp_bub || Flush_count !== exp_fl) begin
      n_bad++; $display("FAIL fl_lu_count: bub=%0d fl=%0d want %0d %0d", Bubble_count, Flush_count, exp_bub, exp_fl);
    end
`endif
  endtask

  task automatic test_halt();
    set_idle();
    R1_data = 32'hAA; R2_data = 32'hBB; ID_PC = 32'h200; ID_imm = 32'h10; ID_Write_Reg = 5'd9;
    step();
    Halt = 1; Flush = 1;
    R1_data = 32'h11; ID_PC = 32'h300; ID_Write_Reg = 5'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (EX_A !== 32'hAA || EX_B !== 32'hBB || EX_PC !== 32'h200 || EX_imm !== 32'h10 ||
          EX_valid !== 1'b1 || EX_Write_Reg !== 5'd9) begin
        n_bad++; $display("FAIL halt_hold_%0d: A=%h PC=%h valid=%b wr=%0d", i, EX_A, EX_PC, EX_valid, EX_Write_Reg);
      end
`ifdef BUBBLE_STAT_EN
      n_cmp++;
      if (Bubble_count !== exp_bub || Flush_count !== exp_fl) begin
        n_bad++; $display("FAIL halt_count_%0d: bub=%0d fl=%0d want %0d %0d", i, Bubble_count, Flush_count, exp_bub, exp_fl);
      end
`endif
    end
    Halt = 0;
    step();
`ifdef BUBBLE_STAT_EN
    exp_fl++;
`endif
    n_cmp++;
    if (EX_valid !== 1'b0 || EX_A !== 32'h0 || EX_PC !== 32'h0) begin
      n_bad++; $display("FAIL halt_release: valid=%b A=%h PC=%h want bubble", EX_valid, EX_A, EX_PC);
    end
`ifdef BUBBLE_STAT_EN
    n_cmp++;
    if (Flush_count !== exp_fl) begin
      n_bad++; $display("FAIL halt_release_count: fl=%0d want %0d", Flush_count, exp_fl);
    end
`endif
  endtask

  task automatic test_invalid();
    set_idle();
    ID_valid = 0; R1_data = 32'h55; ID_Reg_Write = 1; ID_Write_Reg = 5'd7;
    step();
    n_cmp++;
    if (EX_valid !== 1'b0 || EX_A !== 32'h0 || EX_Reg_Write !== 1'b0 || EX_Write_Reg !== 5'd0) begin
      n_bad++; $display("FAIL invalid_bubble: valid=%b A=%h rw=%b wr=%0d", EX_valid, EX_A, EX_Reg_Write, EX_Write_Reg);
    end
`ifdef BUBBLE_STAT_EN
    n_cmp++;
    if (Bubble_count !== exp_bub || Flush_count !== exp_fl) begin
      n_bad++; $display("FAIL invalid_count: bub=%0d fl=%0d want %0d %0d", Bubble_count, Flush_count, exp_bub, exp_fl);
    end
`endif
  endtask

  task automatic test_back_to_back();
    set_idle();
    R1_data = 32'h99;
    Load_use = 1;
    for (int i = 0; i < 3; i++) begin
      step();
`ifdef BUBBLE_STAT_EN
      exp_bub++;
`endif
      n_cmp++;
      if (EX_valid !== 1'b0 || EX_A !== 32'h0) begin
        n_bad++; $display("FAIL b2b_bubble_%0d: valid=%b A=%h", i, EX_valid, EX_A);
      end
    end
    Load_use = 0;
    step();
    n_cmp++;
    if (EX_valid !== 1'b1 || EX_A !== 32'h99) begin
      n_bad++; $display("FAIL b2b_resume: valid=%b A=%h want 1 99", EX_valid, EX_A);
    end
`ifdef BUBBLE_STAT_EN
    n_cmp++;
    if (Bubble_count !== exp_bub) begin
      n_bad++; $display("FAIL b2b_count: bub=%0d want %0d", Bubble_count, exp_bub);
    end
`endif
  endtask

`ifdef BUBBLE_STAT_EN
  task automatic test_saturation();
    set_idle();
    @(negedge clk);
    force dut.bubble_count_q = 32'hFFFF_FFFE;
    #1 release dut.bubble_count_q;
    Load_use = 1;
    for (int i = 0; i < 3; i++) step();
    Load_use = 0;
    n_cmp++;
    if (Bubble_count !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL sat_bubble: bub=%h want FFFFFFFF", Bubble_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_load_use();
    test_halt();
    test_invalid();
    test_back_to_back();
`ifdef BUBBLE_STAT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
